// File: rtl/traffic_phase_fsm.sv
// Traffic intersection phase sequencer: main/side green-yellow-red cycling with
// demand-driven side phase, bounded main-green extension and night flashing mode.
module traffic_phase_fsm #(
  parameter int MAX_EXTEND = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       g_end,
  input  logic       y_end,
  input  logic       r_end,
  input  logic       side_car,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic       fsm_g,
  output logic       fsm_y,
  output logic       fsm_r,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk
);

  localparam int EXT_W = (MAX_EXTEND < 2) ? 1 : $clog2(MAX_EXTEND + 1);
  localparam logic [EXT_W-1:0] EXT_LIMIT = EXT_W'(MAX_EXTEND);
  localparam logic [EXT_W-1:0] EXT_ONE   = EXT_W'(1);

  typedef enum logic [2:0] {
    MAIN_G,
    MAIN_Y,
    ALL_R1,
    SIDE_G,
    SIDE_Y,
    ALL_R2,
    FLASH
  } state_t;

  state_t           state, state_n;
  logic             blink, blink_n;
  logic             demand, demand_n;
  logic             ped_latched, ped_latched_n;
  logic             walk_flag, walk_flag_n;
  logic [EXT_W-1:0] ext_cnt, ext_cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALL_R2;
      blink       <= 1'b0;
      demand      <= 1'b0;
      ped_latched <= 1'b0;
      walk_flag   <= 1'b0;
      ext_cnt     <= '0;
    end else begin
      state       <= state_n;
      blink       <= blink_n;
      demand      <= demand_n;
      ped_latched <= ped_latched_n;
      walk_flag   <= walk_flag_n;
      ext_cnt     <= ext_cnt_n;
    end
  end

  // End pulses not belonging to the current phase fall through untouched.
  always_comb begin
    state_n       = state;
    blink_n       = blink;
    demand_n      = demand | side_car | ped_req;
    ped_latched_n = ped_latched | ped_req;
    walk_flag_n   = walk_flag;
    ext_cnt_n     = ext_cnt;

    case (state)
      MAIN_G: begin
        if (g_end) begin
          if (demand || (ext_cnt == EXT_LIMIT)) begin
            state_n   = MAIN_Y;
            ext_cnt_n = '0;
          end else begin
            ext_cnt_n = ext_cnt + EXT_ONE;
          end
        end
      end
      MAIN_Y: begin
        if (y_end) state_n = ALL_R1;
      end
      ALL_R1: begin
        if (r_end) begin
          if (night_mode) begin
            state_n = FLASH;
          end else begin
            // Requests arriving in the entry cycle itself survive the clear.
            state_n       = SIDE_G;
            walk_flag_n   = ped_latched;
            demand_n      = side_car | ped_req;
            ped_latched_n = ped_req;
          end
        end
      end
      SIDE_G: begin
        if (g_end) begin
          state_n     = SIDE_Y;
          walk_flag_n = 1'b0;
        end
      end
      SIDE_Y: begin
        if (y_end) state_n = ALL_R2;
      end
      ALL_R2: begin
        if (r_end) state_n = night_mode ? FLASH : MAIN_G;
      end
      FLASH: begin
        if (y_end) begin
          if (night_mode) begin
            blink_n = ~blink;
          end else begin
            state_n = ALL_R2;
            blink_n = 1'b0;
          end
        end
      end
      default: state_n = ALL_R2;
    endcase
  end

  always_comb begin
    fsm_g      = 1'b0;
    fsm_y      = 1'b0;
    fsm_r      = 1'b1;
    main_light = 3'b100;
    side_light = 3'b100;
    walk       = 1'b0;

    case (state)
      MAIN_G: begin
        fsm_g      = 1'b1;
        fsm_r      = 1'b0;
        main_light = 3'b001;
      end
      MAIN_Y: begin
        fsm_y      = 1'b1;
        fsm_r      = 1'b0;
        main_light = 3'b010;
      end
      SIDE_G: begin
        fsm_g      = 1'b1;
        fsm_r      = 1'b0;
        side_light = 3'b001;
        walk       = walk_flag;
      end
      SIDE_Y: begin
        fsm_y      = 1'b1;
        fsm_r      = 1'b0;
        side_light = 3'b010;
      end
      FLASH: begin
        fsm_y      = 1'b1;
        fsm_r      = 1'b0;
        main_light = {1'b0, blink, 1'b0};
        side_light = {1'b0, blink, 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: doc/traffic_phase_fsm.md
TRAFFIC_PHASE_FSM -- requirements
Module: traffic_phase_fsm

Interface
REQ-001 The block SHALL have parameter MAX_EXTEND, default 4: the maximum number of consecutive main-green re-arms allowed before the side phase is forced.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port g_end, input, 1 bit: a one-cycle pulse from the phase timer marking the end of a green period.
REQ-005 The block SHALL have port y_end, input, 1 bit: a one-cycle pulse from the phase timer marking the end of a yellow period.
REQ-006 The block SHALL have port r_end, input, 1 bit: a one-cycle pulse from the phase timer marking the end of an all-red period.
REQ-007 The block SHALL have port side_car, input, 1 bit: the side-road vehicle sensor (level).
REQ-008 The block SHALL have port ped_req, input, 1 bit: the pedestrian button (level or pulse).
REQ-009 The block SHALL have port night_mode, input, 1 bit: the flashing-yellow request (level).
REQ-010 The block SHALL have port fsm_g, output, 1 bit: tells the phase timer that a green phase is active.
REQ-011 The block SHALL have port fsm_y, output, 1 bit: tells the phase timer that a yellow or flash phase is active.
REQ-012 The block SHALL have port fsm_r, output, 1 bit: tells the phase timer that an all-red phase is active.
REQ-013 The block SHALL have port main_light, output, 3 bits, encoded {red, yellow, green}: the main-road lamps.
REQ-014 The block SHALL have port side_light, output, 3 bits, same encoding: the side-road lamps.
REQ-015 The block SHALL have port walk, output, 1 bit: the pedestrian walk lamp.

Function
REQ-016 The block SHALL implement states MAIN_G, MAIN_Y, ALL_R1, SIDE_G, SIDE_Y, ALL_R2 and FLASH; all outputs SHALL be registered or decoded from state only.
REQ-017 Exactly one of fsm_g, fsm_y and fsm_r SHALL be high in every cycle.
- fsm_g is high in MAIN_G and SIDE_G.
- fsm_y is high in MAIN_Y, SIDE_Y and FLASH.
- fsm_r is high in ALL_R1 and ALL_R2.
REQ-018 Lamp outputs SHALL be as follows (main/side):
- MAIN_G: 001/100
- MAIN_Y: 010/100
- ALL_R1, ALL_R2: 100/100
- SIDE_G: 100/001
- SIDE_Y: 100/010
- FLASH: {0,blink,0} on both roads
REQ-019 A demand flag SHALL be set in any cycle where side_car or ped_req is high; ped_req SHALL also set a separate ped_latched flag.
REQ-020 On the transition into SIDE_G:
- walk_flag is loaded from ped_latched.
- demand and ped_latched are cleared.
- If side_car or ped_req is high in that same cycle, set wins and the request is retained for the next cycle.
REQ-021 walk SHALL equal walk_flag while in SIDE_G and SHALL be 0 in all other states.
REQ-022 In MAIN_G, on g_end:
- If demand is 1 or ext_cnt equals MAX_EXTEND, the block goes to MAIN_Y and clears ext_cnt.
- Otherwise it stays in MAIN_G and increments ext_cnt.
- ext_cnt SHALL be wide enough to hold MAX_EXTEND and SHALL never wrap.
REQ-023 The remaining phase transitions SHALL be:
- MAIN_Y on y_end goes to ALL_R1.
- SIDE_G on g_end goes to SIDE_Y.
- SIDE_Y on y_end goes to ALL_R2.
REQ-024 On r_end, ALL_R1 SHALL go to FLASH if night_mode is 1, else to SIDE_G; ALL_R2 SHALL go to FLASH if night_mode is 1, else to MAIN_G.
REQ-025 In FLASH, each y_end SHALL toggle blink; if night_mode is 0 at y_end, the block SHALL go to ALL_R2 with blink cleared.
REQ-026 night_mode SHALL be honoured only at the ALL_R1/ALL_R2 r_end boundaries and at FLASH y_end; it SHALL never cut short a green or yellow phase.
REQ-027 An end pulse that does not match the current state's active fsm_* output SHALL be ignored, with no state or flag change (for example, y_end during MAIN_G).
REQ-028 Every state transition SHALL take effect on the clock edge that samples the matching end pulse (1-cycle latency), so the new fsm_* output is visible in the following cycle.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL enter ALL_R2 with the following values:
- fsm_r=1, fsm_g=0, fsm_y=0
- main_light=100, side_light=100, walk=0
- blink=0, demand=0, ped_latched=0, walk_flag=0, ext_cnt=0
REQ-030 Reset asserted in any state, including FLASH or mid-extension, SHALL override all inputs in that cycle, and the values in REQ-029 SHALL appear in the next cycle.

Verification
REQ-031 Reset then one r_end -> MAIN_G entered; fsm_g=1, main_light=001, side_light=100 on the next cycle.
REQ-032 In MAIN_G with no demand, 5 g_end pulses at MAX_EXTEND=4 -> first 4 keep MAIN_G (ext_cnt 1..4); the 5th moves to MAIN_Y.
REQ-033 ped_req pulse during MAIN_G, then g_end, y_end, r_end -> SIDE_G with walk=1 and side_light=001; the following g_end gives SIDE_Y with walk=0.
REQ-034 side_car high in the exact SIDE_G entry cycle -> demand still 1 afterwards; the next MAIN_G g_end goes directly to MAIN_Y.
REQ-035 night_mode=1 during SIDE_G -> no effect until ALL_R2 r_end, which enters FLASH; y_end pulses toggle main_light 000/010; night_mode=0 then y_end -> ALL_R2 with fsm_r=1.
REQ-036 Spurious g_end in ALL_R1 and y_end in SIDE_G -> no state change; rst pulse in FLASH -> ALL_R2 with walk=0 and blink=0 next cycle.
